// File: rtl/europa_audio_pkg.sv
// Shared definitions for the Europa audio path: sample width default and
// the sigma-delta DAC sequencer state codes.
package europa_audio_pkg;

    localparam int DATA_W_DEFAULT     = 16;
    localparam int SAMPLE_DIV_DEFAULT = 125;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_RUN    = 2'd2,
        ST_STARVE = 2'd3
    } dac_state_e;

endpackage

// File: rtl/europa_sd_dac_if.sv
// Sample stream handshake into the sigma-delta DAC: valid/ready with a
// signed sample word.
interface europa_sd_dac_if #(
    parameter int DATA_W = 16
) ();

    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/europa_sync_fifo.sv
// Small first-word-fall-through FIFO: head word visible on pop_data while
// not empty, pop strobe advances it, flush empties it in one cycle.
module europa_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    // Refusing pushes while flushing keeps the handshake honest on that cycle.
    assign push_ready = ~full & ~flush;
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop & ~empty;
    assign pop_data   = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/europa_sd_dac.sv
// First-order sigma-delta audio DAC: buffered sample stream, sample-rate
// sequencer with underrun detection, and a 1-bit density modulator.
module europa_sd_dac
    import europa_audio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr_underrun,
    europa_sd_dac_if.slave   s,
    output logic             dac_out,
    output logic             underrun,
    output logic [1:0]       state_o
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    dac_state_e        state_q;
    logic [DATA_W-1:0] cur_sample_q;
    logic              underrun_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic              dac_q;

    logic              tick;
    logic              flush;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              playing;
    logic              underrun_set;
    logic [DATA_W-1:0] mod_u;
    logic [DATA_W:0]   mod_sum;

    assign tick    = enable && (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
    assign flush   = ~enable && (state_q != ST_IDLE);
    assign playing = (state_q == ST_RUN) || (state_q == ST_STARVE);

    // PRIME waits for two buffered samples so the first RUN period has slack.
    assign fifo_pop = tick && (((state_q == ST_PRIME) && (fifo_count >= OCC_W'(2)))
                               || (playing && !fifo_empty));
    assign underrun_set = tick && playing && fifo_empty;

    europa_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (s.s_valid),
        .push_ready (s.s_ready),
        .push_data  (s.s_data),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (!enable || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_sample_q <= '0;
            underrun_q   <= 1'b0;
        end else begin
            // A fresh underrun outranks a clear arriving in the same cycle.
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (clr_underrun) begin
                underrun_q <= 1'b0;
            end

            if (!enable) begin
                state_q      <= ST_IDLE;
                cur_sample_q <= '0;
            end else begin
                if (fifo_pop) begin
                    cur_sample_q <= fifo_head;
                end
                case (state_q)
                    ST_IDLE:   state_q <= ST_PRIME;
                    ST_PRIME:  if (fifo_pop) state_q <= ST_RUN;
                    ST_RUN:    if (underrun_set) state_q <= ST_STARVE;
                    ST_STARVE: if (fifo_pop) state_q <= ST_RUN;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Offset binary: flipping the sign bit maps -full..+full onto 0..2^N-1.
    assign mod_u   = (state_q == ST_IDLE) ? MIDSCALE
                                          : {~cur_sample_q[DATA_W-1], cur_sample_q[DATA_W-2:0]};
    assign mod_sum = {1'b0, acc_q} + {1'b0, mod_u};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= mod_sum[DATA_W-1:0];
            dac_q <= mod_sum[DATA_W];
        end
    end

    assign dac_out  = dac_q;
    assign underrun = underrun_q;
    assign state_o  = state_q;

endmodule
